mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory controller that shares the CPU's byte-wide RAM/IO bus between the instruction fetcher and the load/store buffer. It serialises multi-byte accesses into byte transactions and assembles little-endian read data. It returns one-cycle completion pulses to each requester. It sits between the fetch/issue front end, the LSB and the top-level memory pins, and is the only driver of `mem_a`/`mem_dout`/`mem_wr`.

## Interface
- No parameters; access length is fixed by a 2-bit per-request code.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset. **Asynchronous, active-low.**
- `rdy_in` in 1: global enable. Low freezes all state.
- `_clear` in 1: mispredict flush from ROB.
- `io_buffer_full` in 1: UART buffer full.
- `_if_req` in 1: fetch request, level.
- `_if_addr` in 32: fetch address.
- `_if_ready` out 1: fetch done pulse.
- `_if_inst` out 32: fetched word, valid with `_if_ready`.
- `_lsb_req` in 1: LSB request, level.
- `_lsb_wr` in 1: 1 = store, 0 = load.
- `_lsb_len` in 2: access length. 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `_lsb_addr` in 32: LSB access address.
- `_lsb_wdata` in 32: store data.
- `_lsb_ready` out 1: LSB done pulse.
- `_lsb_rdata` out 32: load data, zero-extended, valid with `_lsb_ready`.
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: write strobe.

## Operation
- **States:** IDLE, IF_RD, LS_RD, LS_WR. Supporting registers:
  - byte counter `cnt[2:0]`
  - latched base address, length N (1/2/4) and write data
  - 32-bit assembly register
  - `last_lsb` fairness bit
- **IDLE arbitration:**
  - Only one request valid: grant it.
  - Both valid: grant the one not served last (`last_lsb`).
  - On grant, latch address, length and data; set `cnt=0`.
  - IF requests always have N=4.
- **Reads (IF_RD, LS_RD):**
  - While `cnt<N`: drive `mem_a=base+cnt`, `mem_wr=0`.
  - RAM returns the byte one cycle later. The byte from `base+k` is written into assembly bits `[8k+7:8k]`.
  - After the last byte is captured: pulse the requester's ready with the data, clear unused upper bytes, go to IDLE.
- **Writes (LS_WR):**
  - Each cycle with `cnt<N`: drive `mem_a=base+cnt`, `mem_dout=wdata[8cnt+7:8cnt]`, `mem_wr=1`, then increment `cnt`.
  - After byte N-1: pulse `_lsb_ready`, go to IDLE.
- **IO backpressure:** if `io_buffer_full=1` and `base[17:16]==2'b11`, the write cycle is held. `mem_wr=0` and `cnt` does not advance.
- **Idle bus values:** `mem_a=0`, `mem_wr=0`, `mem_dout=0`.
- **`_clear`:**
  - In IF_RD or LS_RD: abort to IDLE next cycle, no ready pulse.
  - In LS_WR: ignored. Committed stores always complete.
  - In IDLE: suppresses a grant to IF that cycle.
- **Requester rule:** in the cycle a ready pulse is high, that requester's `req` is not sampled. The requester must drop or replace `req` by the next cycle.
- **`rdy_in=0`:** every register holds and `mem_wr` is forced 0. The in-flight read byte pipeline must tolerate this: re-issue the current address on resume, and do not capture `mem_din` while `rdy_in=0`.

## Timing
Cycle 0 = request high while in IDLE.
- **Read:** addresses driven in cycles 1..N. Ready pulse in cycle N+2.
  - Word: cycle 6. Byte: cycle 3.
- **Write:** strobes in cycles 1..N. Ready pulse in cycle N+1.
  - Byte: cycle 2. Word: cycle 5.
- **Back-to-back:** IDLE is re-entered in the ready cycle, so a new grant may take effect with addresses from the following cycle.
- **Ready outputs:** registered, high for exactly one cycle.
- **Data outputs:** `_if_inst`/`_lsb_rdata` hold their value until the next ready pulse.
- **Reset values** (`rst_in` low, immediately):
  - State IDLE; `cnt`, all outputs and assembly register = 0.
  - `last_lsb=0`, so IF wins the first tie.

## Test plan
- **Fetch read:** RAM[0x100..0x103]=13,05,A0,00; `_if_req`, addr 0x100 → `mem_a` 0x100..0x103 in cycles 1-4; `_if_ready` in cycle 6 with `_if_inst=0x00A00513`.
- **Tie fairness:** `_if_req` and `_lsb_req` both high from reset (LSB byte load @0x200 = 0xFF) → IF served first; LSB ready with `_lsb_rdata=0x000000FF` after the IF completes; next tie goes to IF.
- **Half store:** 0x1234 to 0x300 → `mem_wr` in cycles 1-2 with (0x300, 0x34), (0x301, 0x12); `_lsb_ready` in cycle 3; RAM[0x302] untouched.
- **IO stall:** byte store to 0x30000 with `io_buffer_full=1` for 3 cycles → no `mem_wr` until it drops; then one write and ready one cycle later.
- **Flush:** `_clear` in cycle 3 of a fetch → no `_if_ready`; IDLE in cycle 4. `_clear` during a word store → all 4 bytes still written and ready still pulses.
- **Reset/pause:** `rst_in` low mid-read → outputs 0 and state IDLE asynchronously. `rdy_in` low for 2 cycles mid-word-read → data still correct, ready delayed by exactly 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter: shares the byte-wide RAM/IO bus between instruction fetch and
// the LSB, serialising multi-byte accesses into little-endian byte cycles.
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        io_buffer_full,
    input  logic        _if_req,
    input  logic [31:0] _if_addr,
    output logic        _if_ready,
    output logic [31:0] _if_inst,
    input  logic        _lsb_req,
    input  logic        _lsb_wr,
    input  logic [1:0]  _lsb_len,
    input  logic [31:0] _lsb_addr,
    input  logic [31:0] _lsb_wdata,
    output logic        _lsb_ready,
    output logic [31:0] _lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic [2:0]  len_n;
    logic [2:0]  pend_idx;
    logic [2:0]  lsb_n;
    logic        pend;
    logic        last_lsb;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] asm_data;
    logic [31:0] merged;
    logic        if_valid;
    logic        lsb_valid;
    logic        grant_if;
    logic        grant_lsb;
    logic        issue;
    logic        capture;
    logic        rd_done;
    logic        wr_step;
    logic        wr_done;
    logic        io_hold;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        grant_if  = 1'b0;
        grant_lsb = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        rd_done   = 1'b0;
        wr_step   = 1'b0;
        wr_done   = 1'b0;
        mem_a     = 32'd0;
        mem_dout  = 8'd0;
        mem_wr    = 1'b0;
        merged    = asm_data;
        merged[{pend_idx[1:0], 3'b000} +: 8] = mem_din;
        lsb_n     = (_lsb_len == 2'd0) ? 3'd1 : (_lsb_len == 2'd1) ? 3'd2 : 3'd4;
        // A requester is not sampled in the cycle its own ready pulse is high.
        if_valid  = _if_req && !_if_ready && !_clear;
        lsb_valid = _lsb_req && !_lsb_ready;
        io_hold   = io_buffer_full && (base[17:16] == 2'b11);

        case (state)
            IDLE: begin
                if (if_valid && lsb_valid) begin
                    grant_lsb = last_lsb;
                    grant_if  = !last_lsb;
                end else begin
                    grant_if  = if_valid;
                    grant_lsb = lsb_valid;
                end
                if (grant_if) begin
                    state_nx = IF_RD;
                end else if (grant_lsb) begin
                    state_nx = _lsb_wr ? LS_WR : LS_RD;
                end
            end
            IF_RD, LS_RD: begin
                issue   = (cnt < len_n);
                capture = pend;
                // While paused, keep presenting the byte still awaiting capture so
                // mem_din carries it again in the first cycle after resume.
                if (!rdy_in && pend) begin
                    mem_a = base + {29'd0, pend_idx};
                end else if (issue) begin
                    mem_a = base + {29'd0, cnt};
                end
                rd_done = pend && (pend_idx == len_n - 3'd1) && !_clear;
                if (_clear || rd_done) begin
                    state_nx = IDLE;
                end
            end
            LS_WR: begin
                mem_a    = base + {29'd0, cnt};
                mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                wr_step  = !io_hold && rdy_in;
                mem_wr   = wr_step;
                wr_done  = wr_step && (cnt == len_n - 3'd1);
                if (wr_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt        <= 3'd0;
            len_n      <= 3'd0;
            pend_idx   <= 3'd0;
            pend       <= 1'b0;
            last_lsb   <= 1'b0;
            base       <= 32'd0;
            wdata      <= 32'd0;
            asm_data   <= 32'd0;
            _if_ready  <= 1'b0;
            _if_inst   <= 32'd0;
            _lsb_ready <= 1'b0;
            _lsb_rdata <= 32'd0;
        end else if (rdy_in) begin
            _if_ready  <= 1'b0;
            _lsb_ready <= 1'b0;
            pend       <= issue;
            if (grant_if || grant_lsb) begin
                base     <= grant_if ? _if_addr : _lsb_addr;
                len_n    <= grant_if ? 3'd4 : lsb_n;
                wdata    <= _lsb_wdata;
                cnt      <= 3'd0;
                asm_data <= 32'd0;
                // 0: IF takes the next tie, 1: LSB takes the next tie.
                last_lsb <= grant_if;
            end
            if (issue) begin
                cnt      <= cnt + 3'd1;
                pend_idx <= cnt;
            end
            if (wr_step) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                asm_data <= merged;
            end
            if (rd_done) begin
                if (state == IF_RD) begin
                    _if_ready <= 1'b1;
                    _if_inst  <= merged;
                end else begin
                    _lsb_ready <= 1'b1;
                    _lsb_rdata <= merged;
                end
            end
            if (wr_done) begin
                _lsb_ready <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte RAM model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        _clear = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic        _if_req = 1'b0;
    logic [31:0] _if_addr = 32'd0;
    logic        _if_ready;
    logic [31:0] _if_inst;
    logic        _lsb_req = 1'b0;
    logic        _lsb_wr = 1'b0;
    logic [1:0]  _lsb_len = 2'd0;
    logic [31:0] _lsb_addr = 32'd0;
    logic [31:0] _lsb_wdata = 32'd0;
    logic        _lsb_ready;
    logic [31:0] _lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        .io_buffer_full (io_buffer_full),
        ._if_req        (_if_req),
        ._if_addr       (_if_addr),
        ._if_ready      (_if_ready),
        ._if_inst       (_if_inst),
        ._lsb_req       (_lsb_req),
        ._lsb_wr        (_lsb_wr),
        ._lsb_len       (_lsb_len),
        ._lsb_addr      (_lsb_addr),
        ._lsb_wdata     (_lsb_wdata),
        ._lsb_ready     (_lsb_ready),
        ._lsb_rdata     (_lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    rsp_t       if_q[$];
    rsp_t       lsb_q[$];
    wr_t        wr_q[$];
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         last_wr_cyc = -1;
    int         txn_c0 = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Byte RAM with one cycle of read latency.
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
        logic [31:0] d;
        d = 32'd0;
        for (int k = 0; k < n; k++) d[8*k +: 8] = ref_mem[16'(addr + 32'(k))];
        return d;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response or a write.
    always @(negedge clk_in) begin
        rsp_t e;
        wr_t  w;
        if (rst_in) begin
            if (_if_ready) begin
                if (if_q.size() == 0) chk(1'b0, "if_ready_unexpected", 32'd1, 32'd0);
                else begin
                    e = if_q.pop_front();
                    chk(cyc == e.cyc, "if_ready_cycle", 32'(cyc), 32'(e.cyc));
                    chk(_if_inst == e.data, "if_inst", _if_inst, e.data);
                end
            end
            if (_lsb_ready) begin
                if (lsb_q.size() == 0) chk(1'b0, "lsb_ready_unexpected", 32'd1, 32'd0);
                else begin
                    e = lsb_q.pop_front();
                    chk(cyc == e.cyc, "lsb_ready_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk_data) chk(_lsb_rdata == e.data, "lsb_rdata", _lsb_rdata, e.data);
                end
            end
            if (mem_wr) begin
                last_wr_cyc = cyc;
                if (wr_q.size() == 0) chk(1'b0, "mem_wr_unexpected", mem_a, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    chk(mem_a == w.addr, "wr_addr", mem_a, w.addr);
                    chk(mem_dout == w.data, "wr_data", 32'(mem_dout), 32'(w.data));
                end
            end
        end
    end

    // One transaction from an idle DUT; expectations are pushed when it is issued.
    task automatic do_txn(input bit is_if, input bit wr, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, input int p_at, input int p_len, input int stall,
                          input int clr_at);
        int   n;
        int   lat;
        bit   store;
        bit   io;
        rsp_t e;
        wr_t  w;
        store = !is_if && wr;
        io    = (addr[17:16] == 2'b11);
        n     = is_if ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        lat   = (store ? n + 1 : n + 2) + p_len + ((store && io) ? stall : 0);
        @(posedge clk_in); #1;
        txn_c0 = cyc;
        if (is_if) begin
            _if_req  = 1'b1;
            _if_addr = addr;
        end else begin
            _lsb_req   = 1'b1;
            _lsb_wr    = wr;
            _lsb_len   = len;
            _lsb_addr  = addr;
            _lsb_wdata = wd;
        end
        e.cyc      = txn_c0 + lat;
        e.chk_data = !store;
        e.data     = 32'd0;
        if (store) begin
            for (int k = 0; k < n; k++) begin
                ref_mem[16'(addr + 32'(k))] = wd[8*k +: 8];
                w.addr = addr + 32'(k);
                w.data = wd[8*k +: 8];
                wr_q.push_back(w);
            end
            lsb_q.push_back(e);
        end else if (clr_at == 0) begin
            e.data = ref_read(addr, n);
            if (is_if) if_q.push_back(e);
            else lsb_q.push_back(e);
        end
        for (int t = 1; t <= lat + 1; t++) begin
            @(posedge clk_in); #1;
            if (t == 1) begin
                _if_req  = 1'b0;
                _lsb_req = 1'b0;
            end
            rdy_in         = !(p_len > 0 && t >= p_at && t < p_at + p_len);
            io_buffer_full = io ? (t <= stall) : 1'($urandom_range(0, 1));
            _clear         = (t == clr_at);
            if (clr_at > 0 && !store && t == clr_at + 1)
                chk(mem_a == 32'd0, "flush_bus_idle", mem_a, 32'd0);
        end
        rdy_in         = 1'b1;
        io_buffer_full = 1'b0;
        _clear         = 1'b0;
    endtask

    // IF and a byte load raised together: IF first, LSB granted in the IF ready cycle.
    task automatic tie_pair(input logic [31:0] ia, input logic [31:0] la);
        rsp_t e;
        @(posedge clk_in); #1;
        txn_c0    = cyc;
        _if_req   = 1'b1;
        _if_addr  = ia;
        _lsb_req  = 1'b1;
        _lsb_wr   = 1'b0;
        _lsb_len  = 2'd0;
        _lsb_addr = la;
        e.chk_data = 1'b1;
        e.data     = ref_read(ia, 4);
        e.cyc      = txn_c0 + 6;
        if_q.push_back(e);
        e.data = ref_read(la, 1);
        e.cyc  = txn_c0 + 9;
        lsb_q.push_back(e);
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk_in); #1;
            if (t == 1) _if_req = 1'b0;
            if (t == 7) _lsb_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          r_if;
        bit          r_wr;
        logic [1:0]  r_len;
        logic [31:0] r_addr;
        int          r_n;
        int          r_pat;
        int          r_plen;
        int          r_stall;

        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'hA0; ram[16'h103] = 8'h00;
        ram[16'h200] = 8'hFF;
        for (int i = 16'h100; i < 16'h104; i++) ref_mem[i] = ram[i];
        ref_mem[16'h200] = ram[16'h200];

        repeat (3) @(posedge clk_in);
        #1;
        chk(_if_ready == 1'b0, "rst_if_ready", 32'(_if_ready), 32'd0);
        chk(_lsb_ready == 1'b0, "rst_lsb_ready", 32'(_lsb_ready), 32'd0);
        chk(_if_inst == 32'd0, "rst_if_inst", _if_inst, 32'd0);
        chk(_lsb_rdata == 32'd0, "rst_lsb_rdata", _lsb_rdata, 32'd0);
        chk(mem_a == 32'd0, "rst_mem_a", mem_a, 32'd0);
        chk(mem_wr == 1'b0, "rst_mem_wr", 32'(mem_wr), 32'd0);
        chk(mem_dout == 8'd0, "rst_mem_dout", 32'(mem_dout), 32'd0);
        rst_in = 1'b1;

        do_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, 0, 0, 0, 0);
        chk(_if_inst == 32'h00A00513, "fetch_word", _if_inst, 32'h00A00513);

        do_txn(1'b0, 1'b1, 2'd1, 32'h300, 32'h1234, 0, 0, 0, 0);
        chk(ram[16'h302] == ref_mem[16'h302], "half_store_untouched", 32'(ram[16'h302]), 32'(ref_mem[16'h302]));

        do_txn(1'b0, 1'b1, 2'd0, 32'h30000, 32'hA5, 0, 0, 3, 0);
        chk(last_wr_cyc == txn_c0 + 4, "io_stall_write_cycle", 32'(last_wr_cyc), 32'(txn_c0 + 4));

        do_txn(1'b1, 1'b0, 2'd0, 32'h104, 32'd0, 0, 0, 0, 3);
        do_txn(1'b0, 1'b1, 2'd2, 32'h400, 32'hDEADBEEF, 0, 0, 0, 2);
        do_txn(1'b1, 1'b0, 2'd0, 32'h100, 32'd0, 3, 2, 0, 0);
        do_txn(1'b0, 1'b0, 2'd2, 32'h400, 32'd0, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r_if    = ($urandom_range(0, 2) == 0);
            r_wr    = 1'($urandom_range(0, 1));
            r_len   = 2'($urandom_range(0, 3));
            r_addr  = 32'($urandom_range(0, 32'hFFF));
            r_stall = 0;
            if (!r_if && r_wr && $urandom_range(0, 4) == 0) begin
                r_addr  = 32'h30000 | 32'($urandom_range(0, 255));
                r_stall = $urandom_range(0, 3);
            end
            r_n    = r_if ? 4 : (r_len == 2'd0) ? 1 : (r_len == 2'd1) ? 2 : 4;
            r_plen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            r_pat  = $urandom_range(1, r_n);
            do_txn(r_if, r_wr, r_len, r_addr, $urandom, r_pat, r_plen, r_stall, 0);
        end

        // Asynchronous reset in the middle of a fetch.
        @(posedge clk_in); #1;
        _if_req  = 1'b1;
        _if_addr = 32'h140;
        @(posedge clk_in); #1;
        _if_req = 1'b0;
        @(posedge clk_in); #3;
        rst_in = 1'b0;
        #1;
        chk(mem_a == 32'd0, "async_rst_mem_a", mem_a, 32'd0);
        chk(mem_wr == 1'b0, "async_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk(_if_ready == 1'b0, "async_rst_if_ready", 32'(_if_ready), 32'd0);
        chk(_if_inst == 32'd0, "async_rst_if_inst", _if_inst, 32'd0);
        chk(_lsb_rdata == 32'd0, "async_rst_lsb_rdata", _lsb_rdata, 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        tie_pair(32'h100, 32'h200);
        chk(_lsb_rdata == 32'h000000FF, "tie_lsb_byte", _lsb_rdata, 32'h000000FF);
        tie_pair(32'h104, 32'h201);

        repeat (4) @(posedge clk_in);
        #1;
        chk(if_q.size() == 0, "if_q_drained", 32'(if_q.size()), 32'd0);
        chk(lsb_q.size() == 0, "lsb_q_drained", 32'(lsb_q.size()), 32'd0);
        chk(wr_q.size() == 0, "wr_q_drained", 32'(wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
